boot_rom_loader: RTL and testbench

- Parametrised successor of the instruction/data ROM. Two asynchronous read ports feed the single-cycle core: an instruction fetch port and a RAM-initialisation data port.
- Replaces the raw word-write port with a byte-serial download engine. The engine takes bytes from the UART/debug link, assembles them into words and writes them at a programmable base.
- While a download is in progress, the core is stalled through cpu_hold.

---
 rtl/boot_rom_loader.sv | 185 ++++++++++++++++++
 tb/tb_boot_rom_loader.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_rom_loader.sv
// Word ROM with two combinational read ports and a byte-serial download engine.
// Optional macro ROM_LOAD_CHECKSUM_EN adds a trailing checksum byte to every download.
module boot_rom_loader #(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 256,
    parameter int    IDX_W     = 8,
    parameter string INIT_FILE = ""
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              load_start,
    input  logic [IDX_W-1:0]  load_base,
    input  logic [IDX_W:0]    load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic              cpu_hold,
    input  logic [31:0]       A,
    output logic [DATA_W-1:0] instruction,
    input  logic [31:0]       RamDataAddress,
    output logic [DATA_W-1:0] RamData
);

    localparam int BPW = DATA_W / 8;
    localparam int BSH = (BPW > 1) ? $clog2(BPW) : 0;
    localparam int KW  = (BPW > 1) ? $clog2(BPW) : 1;

`ifdef ROM_LOAD_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_reg;
    logic [IDX_W-1:0]  ptr_reg;
    logic [IDX_W:0]    words_left_reg;
    logic [KW-1:0]     k_reg;
    logic [DATA_W-1:0] asm_reg;
    logic              byte_ready_reg;
    logic              load_busy_reg;
    logic              load_done_reg;
    logic              load_err_reg;
`ifdef ROM_LOAD_CHECKSUM_EN
    logic [7:0]        sum_reg;
`endif

    logic [IDX_W+1:0]  load_end;
    assign load_end = {2'b00, load_base} + {1'b0, load_len};

    // Both read ports share the same decode: byte address to word index, 0 past the end.
    logic [31:0]       rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    assign rd_addr[0] = A;
    assign rd_addr[1] = RamDataAddress;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [31:0] idx;
            assign idx = rd_addr[gi] >> BSH;
            always_comb begin
                rd_data[gi] = '0;
                if (idx < 32'(DEPTH))
                    rd_data[gi] = mem[idx[IDX_W-1:0]];
            end
        end
    endgenerate

    assign instruction = rd_data[0];
    assign RamData     = rd_data[1];

    // Memory has no reset so its contents survive RST_n.
    always_ff @(posedge CLK) begin
        if (state_reg == S_WRITE)
            mem[ptr_reg] <= asm_reg;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_reg      <= S_IDLE;
            ptr_reg        <= '0;
            words_left_reg <= '0;
            k_reg          <= '0;
            asm_reg        <= '0;
            byte_ready_reg <= 1'b0;
            load_busy_reg  <= 1'b0;
            load_done_reg  <= 1'b0;
            load_err_reg   <= 1'b0;
`ifdef ROM_LOAD_CHECKSUM_EN
            sum_reg        <= '0;
`endif
        end else begin
            load_done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (load_start) begin
                        ptr_reg        <= load_base;
                        words_left_reg <= load_len;
                        k_reg          <= '0;
                        load_err_reg   <= 1'b0;
                        load_busy_reg  <= 1'b1;
`ifdef ROM_LOAD_CHECKSUM_EN
                        sum_reg        <= '0;
`endif
                        if (load_len == '0) begin
                            state_reg     <= S_DONE;
                            load_done_reg <= 1'b1;
                        end else if (load_end > (IDX_W+2)'(DEPTH)) begin
                            load_err_reg  <= 1'b1;
                            state_reg     <= S_DONE;
                            load_done_reg <= 1'b1;
                        end else begin
                            state_reg      <= S_RECV;
                            byte_ready_reg <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (byte_valid) begin
                        asm_reg[8*k_reg +: 8] <= byte_data;
`ifdef ROM_LOAD_CHECKSUM_EN
                        sum_reg <= sum_reg + byte_data;
`endif
                        if (k_reg == KW'(BPW-1)) begin
                            state_reg      <= S_WRITE;
                            byte_ready_reg <= 1'b0;
                        end else begin
                            k_reg <= k_reg + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    ptr_reg        <= ptr_reg + 1'b1;
                    words_left_reg <= words_left_reg - 1'b1;
                    k_reg          <= '0;
                    if (words_left_reg == (IDX_W+1)'(1)) begin
`ifdef ROM_LOAD_CHECKSUM_EN
                        state_reg      <= S_CHECK;
                        byte_ready_reg <= 1'b1;
`else
                        state_reg     <= S_DONE;
                        load_done_reg <= 1'b1;
`endif
                    end else begin
                        state_reg      <= S_RECV;
                        byte_ready_reg <= 1'b1;
                    end
                end
`ifdef ROM_LOAD_CHECKSUM_EN
                S_CHECK: begin
                    // A correct checksum byte brings the running sum to zero.
                    if (byte_valid) begin
                        if (8'(sum_reg + byte_data) != 8'h00)
                            load_err_reg <= 1'b1;
                        state_reg      <= S_DONE;
                        byte_ready_reg <= 1'b0;
                        load_done_reg  <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    state_reg     <= S_IDLE;
                    load_busy_reg <= 1'b0;
                end
                default: begin
                    state_reg      <= S_IDLE;
                    byte_ready_reg <= 1'b0;
                    load_busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_reg;
    assign load_busy  = load_busy_reg;
    assign load_done  = load_done_reg;
    assign load_err   = load_err_reg;
    assign cpu_hold   = load_busy_reg;

endmodule

// File: tb/tb_boot_rom_loader.sv
// Randomised self-checking bench for boot_rom_loader against an array model of the ROM.
module tb_boot_rom_loader;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        load_start = 1'b0;
    logic [7:0]  load_base = '0;
    logic [8:0]  load_len = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, load_busy, load_done, load_err, cpu_hold;
    logic [31:0] A = '0;
    logic [31:0] RamDataAddress = '0;
    logic [31:0] instruction, RamData;

    boot_rom_loader #(.DATA_W(32), .DEPTH(256), .IDX_W(8), .INIT_FILE("")) dut (
        .CLK(CLK), .RST_n(RST_n),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
        .cpu_hold(cpu_hold),
        .A(A), .instruction(instruction),
        .RamDataAddress(RamDataAddress), .RamData(RamData)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [256];
    logic [31:0] wq [$];
    logic [7:0]  tx_q [$];
    int done_cnt = 0;
    int ready_cnt = 0;
    int busy_bad = 0;

    always @(negedge CLK) begin
        if (load_done) begin
            done_cnt++;
            if (!load_busy) busy_bad++;
        end
        if (byte_ready) ready_cnt++;
    end

    task automatic feed(input int gap, input bit poke, input int max_bytes);
        int idx = 0;
        int g = 0;
        int cyc = 0;
        bit poked = 0;
        int n = (max_bytes < 0) ? tx_q.size() : max_bytes;
        while (idx < n && cyc < 20000) begin
            @(negedge CLK);
            cyc++;
            load_start = 1'b0;
            if (g > 0) begin
                byte_valid = 1'b0;
                g--;
                if (poke && !poked) begin
                    load_start = 1'b1;
                    load_base  = 8'd200;
                    load_len   = 9'd1;
                    poked      = 1;
                end
            end else begin
                byte_valid = 1'b1;
                byte_data  = tx_q[idx];
                if (byte_ready) begin
                    idx++;
                    g = gap;
                end
            end
        end
        checks++;
        if (idx != n) begin
            errors++;
            $display("FAIL feed_timeout accepted=%0d required=%0d", idx, n);
        end
        @(posedge CLK);
        #1;
        byte_valid = 1'b0;
        load_start = 1'b0;
    endtask

    task automatic run_load(input int base, input int len, input int gap, input bit bad_chk, input bit poke);
        bit legal, exp_err;
        int d0, r0, b0, cyc;
        logic [7:0]  sum;
        logic [31:0] w;
        legal   = (len > 0) && (base + len <= 256);
        exp_err = (len > 0) && !legal;
        tx_q.delete();
        sum = '0;
        for (int i = 0; i < len; i++) begin
            w = (wq.size() > 0) ? wq.pop_front() : $urandom();
            if (legal) begin
                model[base+i] = w;
                for (int b = 0; b < 4; b++) begin
                    tx_q.push_back(w[8*b +: 8]);
                    sum = sum + w[8*b +: 8];
                end
            end
        end
`ifdef ROM_LOAD_CHECKSUM_EN
        if (legal) begin
            tx_q.push_back(bad_chk ? 8'(1 - sum) : 8'(0 - sum));
            exp_err = bad_chk;
        end
`endif
        d0 = done_cnt; r0 = ready_cnt; b0 = busy_bad;
        @(negedge CLK);
        load_base  = 8'(base);
        load_len   = 9'(len);
        load_start = 1'b1;
        @(negedge CLK);
        load_start = 1'b0;
        checks++;
        if (load_busy !== 1'b1 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start busy=%b hold=%b required=1", load_busy, cpu_hold);
        end
        if (tx_q.size() > 0) feed(gap, poke, -1);
        cyc = 0;
        while (done_cnt == d0 && cyc < 50) begin
            @(posedge CLK);
            cyc++;
        end
        if (!legal) begin
            checks++;
            if (cyc > 2) begin
                errors++;
                $display("FAIL done_latency cycles=%0d required<=2", cyc);
            end
        end
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL done_pulses got=%0d required=1", done_cnt - d0);
        end
        checks++;
        if (load_busy !== 1'b0 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL busy_end busy=%b hold=%b required=0", load_busy, cpu_hold);
        end
        checks++;
        if (load_err !== exp_err) begin
            errors++;
            $display("FAIL load_err got=%b required=%b", load_err, exp_err);
        end
        checks++;
        if (busy_bad !== b0) begin
            errors++;
            $display("FAIL busy_at_done got=%0d required=%0d", busy_bad, b0);
        end
        if (!legal) begin
            checks++;
            if (ready_cnt !== r0) begin
                errors++;
                $display("FAIL ready_never ready_cycles=%0d required=0", ready_cnt - r0);
            end
        end
        $display("load base=%0d len=%0d gap=%0d err=%b", base, len, gap, load_err);
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < 256; i++) begin
            A = 32'(i * 4) + 32'($urandom_range(0, 3));
            RamDataAddress = 32'((255 - i) * 4);
            #1;
            checks += 2;
            if (instruction !== model[i]) begin
                errors++; bad++;
                if (bad < 8) $display("FAIL %s_instr idx=%0d got=%h required=%h", tag, i, instruction, model[i]);
            end
            if (RamData !== model[255-i]) begin
                errors++; bad++;
                if (bad < 8) $display("FAIL %s_ramdata idx=%0d got=%h required=%h", tag, 255 - i, RamData, model[255-i]);
            end
        end
        $display("sweep %s mismatches=%0d", tag, bad);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({byte_ready, load_busy, load_done, load_err, cpu_hold} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b required=00000",
                     {byte_ready, load_busy, load_done, load_err, cpu_hold});
        end
        $display("reset outputs=%b", {byte_ready, load_busy, load_done, load_err, cpu_hold});
    endtask

    task automatic test_basic();
        wq.delete();
        wq.push_back(32'h12345678);
        wq.push_back(32'hDEADBEEF);
        run_load(0, 2, 0, 0, 0);
        A = 32'h4; RamDataAddress = 32'h0;
        #1;
        checks++;
        if (instruction !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_word1 got=%h required=deadbeef", instruction);
        end
        checks++;
        if (RamData !== 32'h12345678) begin
            errors++;
            $display("FAIL basic_word0 got=%h required=12345678", RamData);
        end
        $display("basic instr=%h ramdata=%h", instruction, RamData);
    endtask

    task automatic test_gapped();
        wq.delete();
        wq.push_back(32'h12345678);
        wq.push_back(32'hDEADBEEF);
        run_load(8, 2, 3, 0, 1);
        check_mem("gapped");
    endtask

    task automatic test_range();
        run_load(255, 2, 0, 0, 0);
        run_load(10, 0, 0, 0, 0);
        run_load(0, 300, 0, 0, 0);
        check_mem("range");
    endtask

    task automatic test_reset_mid();
        logic [31:0] w0, w1;
        w0 = $urandom(); w1 = $urandom();
        model[4] = w0;
        tx_q.delete();
        for (int b = 0; b < 4; b++) tx_q.push_back(w0[8*b +: 8]);
        for (int b = 0; b < 4; b++) tx_q.push_back(w1[8*b +: 8]);
        @(negedge CLK);
        load_base = 8'd4; load_len = 9'd2; load_start = 1'b1;
        @(negedge CLK);
        load_start = 1'b0;
        feed(0, 0, 6);
        RST_n = 1'b0;
        #1;
        checks++;
        if ({byte_ready, load_busy, load_done, load_err, cpu_hold} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset got=%b required=00000",
                     {byte_ready, load_busy, load_done, load_err, cpu_hold});
        end
        $display("mid-load reset outputs=%b", {byte_ready, load_busy, load_done, load_err, cpu_hold});
        @(negedge CLK);
        RST_n = 1'b1;
        check_mem("after_reset");
        run_load(4, 2, 1, 0, 0);
        check_mem("reload");
    endtask

    task automatic test_dual_read();
        logic [31:0] a, exp;
        A = 32'h0; RamDataAddress = 32'h4;
        #1;
        checks++;
        if (instruction !== model[0] || RamData !== model[1]) begin
            errors++;
            $display("FAIL dual_read instr=%h ramdata=%h required=%h %h", instruction, RamData, model[0], model[1]);
        end
        A = 32'h400;
        #1;
        checks++;
        if (instruction !== 32'h0) begin
            errors++;
            $display("FAIL out_of_range got=%h required=00000000", instruction);
        end
        $display("dual read A=400 instr=%h", instruction);
        for (int i = 0; i < 16; i++) begin
            a = 32'($urandom_range(0, 32'h47F));
            A = a; RamDataAddress = a;
            exp = (a / 4 < 256) ? model[a/4] : 32'h0;
            #1;
            checks++;
            if (instruction !== exp || RamData !== exp) begin
                errors++;
                $display("FAIL rand_read addr=%h instr=%h ramdata=%h required=%h", a, instruction, RamData, exp);
            end
        end
    endtask

    task automatic test_random_loads();
        int base, len;
        for (int i = 0; i < 12; i++) begin
            base = ($urandom_range(0, 2) == 0) ? $urandom_range(250, 255) : $urandom_range(0, 255);
            len  = $urandom_range(0, 6);
            run_load(base, len, $urandom_range(0, 2), 0, 0);
        end
        check_mem("random");
    endtask

`ifdef ROM_LOAD_CHECKSUM_EN
    task automatic test_checksum();
        wq.delete();
        wq.push_back(32'h12345678);
        wq.push_back(32'hDEADBEEF);
        run_load(0, 2, 0, 0, 0);
        wq.push_back(32'h12345678);
        wq.push_back(32'hDEADBEEF);
        run_load(0, 2, 0, 1, 0);
        check_mem("checksum");
    endtask
`endif

    initial begin
        RST_n = 1'b0;
        repeat (2) @(negedge CLK);
        test_reset();
        @(negedge CLK);
        RST_n = 1'b1;
        run_load(0, 256, 0, 0, 0);
        check_mem("prefill");
        test_basic();
        test_gapped();
        test_range();
        test_reset_mid();
        test_dual_read();
        test_random_loads();
`ifdef ROM_LOAD_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
